// File: rtl/axi4_wr_burst_scheduler.sv
// Round-robin scheduler sharing one AXI4 write channel (AW/W/B) among NUM burst requesters.
// Define AXI4_WR_SCHED_WAIT_BRESP_EN to hold the channel until the matching write response.
module axi4_wr_burst_scheduler #(
  parameter int NUM    = 4,
  parameter int DSIZE  = 128,
  parameter int ASIZE  = 32,
  parameter int LSIZE  = 8,
  parameter int IDSIZE = 4
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic [NUM-1:0]       req_valid,
  output logic [NUM-1:0]       req_ready,
  input  logic [NUM*ASIZE-1:0] req_addr,
  input  logic [NUM*LSIZE-1:0] req_len,
  input  logic [NUM*DSIZE-1:0] s_wdata,
  input  logic [NUM-1:0]       s_wvalid,
  input  logic [NUM-1:0]       s_wlast,
  output logic [NUM-1:0]       s_wready,
  output logic [IDSIZE-1:0]    axi_awid,
  output logic [ASIZE-1:0]     axi_awaddr,
  output logic [LSIZE-1:0]     axi_awlen,
  output logic                 axi_awvalid,
  input  logic                 axi_awready,
  output logic [DSIZE-1:0]     axi_wdata,
  output logic [DSIZE/8-1:0]   axi_wstrb,
  output logic                 axi_wlast,
  output logic                 axi_wvalid,
  input  logic                 axi_wready,
  input  logic [IDSIZE-1:0]    axi_bid,
  input  logic                 axi_bvalid,
  output logic                 axi_bready,
  output logic [NUM-1:0]       grant,
  output logic                 busy,
  output logic                 len_err
);
  // state | meaning
  // IDLE  | no burst owned; arbitrating among req_valid
  // AW    | presenting latched address/len/id until axi_awready
  // W     | routing the granted requester's beats until the one with axi_wlast
  // BRESP | waiting for axi_bvalid carrying our id (response-wait builds only)
  localparam int IDXW = $clog2(NUM);
  localparam int CW   = IDXW + 1;

`ifdef AXI4_WR_SCHED_WAIT_BRESP_EN
  typedef enum logic [1:0] {IDLE, AW, W, BRESP} state_t;
`else
  typedef enum logic [1:0] {IDLE, AW, W} state_t;
`endif

  state_t            state_q, state_d;
  logic [IDXW-1:0]   ptr_q;
  logic [IDXW-1:0]   sel_q;
  logic [ASIZE-1:0]  addr_q;
  logic [LSIZE-1:0]  len_q;
  logic [LSIZE:0]    cnt_q;
  logic              len_err_q;

  logic              pick_found;
  logic [IDXW-1:0]   pick_idx;
  logic [CW-1:0]     cand;
  logic              in_w;
  logic              w_acc;
  logic              wlast_int;

  // ptr_q holds the highest-priority requester for the next arbitration
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 0; i < NUM; i++) begin
      cand = {1'b0, ptr_q} + CW'(i);
      if (cand >= CW'(NUM)) cand = cand - CW'(NUM);
      if (!pick_found && req_valid[cand[IDXW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IDXW-1:0];
      end
    end
  end

  assign in_w      = (state_q == W);
  assign wlast_int = (cnt_q == {1'b0, len_q});
  assign w_acc     = in_w && s_wvalid[sel_q] && axi_wready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (pick_found) state_d = AW;
      AW:   if (axi_awready) state_d = W;
      W: begin
        if (w_acc && wlast_int) begin
`ifdef AXI4_WR_SCHED_WAIT_BRESP_EN
          state_d = BRESP;
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef AXI4_WR_SCHED_WAIT_BRESP_EN
      BRESP: if (axi_bvalid && (axi_bid == axi_awid)) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      sel_q     <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && pick_found) begin
        sel_q  <= pick_idx;
        addr_q <= req_addr[pick_idx*ASIZE +: ASIZE];
        len_q  <= req_len[pick_idx*LSIZE +: LSIZE];
        ptr_q  <= (pick_idx == IDXW'(NUM-1)) ? '0 : pick_idx + 1'b1;
        cnt_q  <= '0;
      end
      if (w_acc) begin
        cnt_q <= wlast_int ? '0 : cnt_q + 1'b1;
        if (s_wlast[sel_q] != wlast_int) len_err_q <= 1'b1;
      end
    end
  end

  // req_ready is the only output that is combinational on inputs in IDLE, so gate it in reset
  assign req_ready   = (state_q == IDLE && pick_found && !rst) ? (NUM'(1) << pick_idx) : '0;
  assign busy        = (state_q != IDLE);
  assign grant       = busy ? (NUM'(1) << sel_q) : '0;
  assign axi_awvalid = (state_q == AW);
  assign axi_awaddr  = addr_q;
  assign axi_awlen   = len_q;
  assign axi_awid    = IDSIZE'(sel_q);
  assign axi_wvalid  = in_w && s_wvalid[sel_q];
  assign axi_wdata   = in_w ? s_wdata[sel_q*DSIZE +: DSIZE] : '0;
  assign axi_wlast   = in_w && wlast_int;
  assign axi_wstrb   = rst ? '0 : '1;
  assign s_wready    = in_w ? (NUM'(axi_wready) << sel_q) : '0;
  assign len_err     = len_err_q;

`ifdef AXI4_WR_SCHED_WAIT_BRESP_EN
  assign axi_bready = (state_q == BRESP);
`else
  // responses are accepted and dropped without holding the channel
  assign axi_bready = 1'b1;
  logic unused_bresp;
  assign unused_bresp = ^{axi_bid, axi_bvalid};
`endif

endmodule

// File: doc/axi4_wr_burst_scheduler.md
AXI4_WR_BURST_SCHEDULER -- requirements
Module: axi4_wr_burst_scheduler

Interface
REQ-001 The block SHALL have parameter NUM, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter DSIZE, default 128, giving the data width.
REQ-003 The block SHALL have parameter ASIZE, default 32, giving the address width.
REQ-004 The block SHALL have parameter LSIZE, default 8, giving the awlen width.
REQ-005 The block SHALL have parameter IDSIZE, default 4, giving the AXI ID width, with IDSIZE >= clog2(NUM).
REQ-006 The block SHALL have the following ports:
- clock, input, 1: sole clock.
- rst, input, 1: reset, asynchronous, active-high.
- req_valid / req_ready, in / out, NUM: per-requester burst request handshake.
- req_addr, in, NUM*ASIZE: packed burst start address, requester i at slice i.
- req_len, in, NUM*LSIZE: packed beats-1 (AXI awlen encoding).
- s_wdata, in, NUM*DSIZE: packed write data.
- s_wvalid / s_wlast / s_wready, in / in / out, NUM: per-requester data stream.
- axi_awid / axi_awaddr / axi_awlen, out, IDSIZE / ASIZE / LSIZE: write address channel.
- axi_awvalid / axi_awready, out / in, 1: write address handshake.
- axi_wdata / axi_wstrb / axi_wlast, out, DSIZE / DSIZE/8 / 1: write data channel.
- axi_wvalid / axi_wready, out / in, 1: write data handshake.
- axi_bid / axi_bvalid / axi_bready, in / in / out, IDSIZE / 1 / 1: write response channel.
- grant, out, NUM: one-hot owner of the channel, 0 when idle.
- busy, out, 1: high in any state except IDLE.
- len_err, out, 1: sticky flag for an s_wlast mismatch.

Function
REQ-007 The FSM SHALL have states IDLE, AW, W, BRESP (BRESP only with the macro) and transition IDLE->AW->W->(BRESP)->IDLE.
REQ-008 In IDLE with any req_valid high, the block SHALL pick a requester by round-robin starting at (last_grant+1) mod NUM.
REQ-009 On that pick, the block SHALL pulse req_ready[sel] for exactly one cycle, latch addr/len/index, set grant, and enter AW on the next cycle.
REQ-010 After reset the round-robin pointer SHALL make requester 0 highest priority.
REQ-011 In AW, axi_awvalid SHALL be 1 with axi_awaddr/axi_awlen equal to the latched values and axi_awid equal to the zero-extended grant index.
REQ-012 AW SHALL hold until axi_awready, then move to W; axi_awvalid SHALL be low in all other states.
REQ-013 In W, the block SHALL combinationally route s_wdata/s_wvalid of the granted requester to axi_w* and axi_wready to s_wready[grant]; all other s_wready SHALL be 0.
REQ-014 axi_wstrb SHALL be all ones.
REQ-015 W SHALL perform no data transfer while in AW: AW precedes W, with no early data.
REQ-016 A beat counter (LSIZE+1 bits) SHALL count accepted beats.
REQ-017 axi_wlast SHALL be 1 exactly when count == latched len, independent of s_wlast.
REQ-018 len_err SHALL set when an accepted beat has s_wlast != axi_wlast; it clears only on reset.
REQ-019 The block SHALL leave W on the beat accepted with axi_wlast.
REQ-020 len = 0 SHALL give a single beat with wlast on the first beat.
REQ-021 len = 2^LSIZE-1 SHALL complete without counter wrap.
REQ-022 A requester dropping req_valid after its grant SHALL NOT abort the burst.
REQ-023 The block SHALL grant at most one burst at a time, with no overlap of AW/W between requesters.

Reset
REQ-024 While rst is high, every output SHALL be 0 (req_ready, s_wready, axi_awvalid, axi_wvalid, axi_wlast, grant, busy, len_err, all address/ID/length fields), and the FSM SHALL be IDLE, counter 0, pointer at requester 0.
REQ-025 rst asserted mid-burst SHALL abandon the burst immediately, with no further beats after rst deasserts.

Configuration
REQ-026 With macro AXI4_WR_SCHED_WAIT_BRESP_EN defined, the block SHALL enter BRESP after the last beat and drive axi_bready = 1 only in BRESP.
REQ-027 With the macro defined, the block SHALL return to IDLE only on axi_bvalid with axi_bid == latched ID, and SHALL ignore responses with other IDs.
REQ-028 With the macro undefined, axi_bready SHALL be tied to 1, there SHALL be no BRESP state, and W SHALL go directly to IDLE.

Verification
REQ-029 Reset then req_valid[2] with addr 0x1000, len 3 -> req_ready[2] 1 cycle, axi_awaddr 0x1000, awlen 3, awid 2, 4 beats, wlast on beat 4.
REQ-030 All four req_valid held high for 8 bursts -> grant order 0,1,2,3,0,1,2,3, with no AW overlap.
REQ-031 Burst len 0 with s_wlast asserted on the first beat -> one beat, axi_wlast 1, len_err stays 0.
REQ-032 len 3 with s_wlast on beat 2 -> len_err = 1 after beat 2, burst still 4 beats.
REQ-033 rst pulsed during beat 2 of a len 7 burst -> all outputs 0, busy 0, and the next grant goes to requester 0.
REQ-034 With AXI4_WR_SCHED_WAIT_BRESP_EN, bvalid with a wrong bid then the correct bid -> block stays in BRESP until the correct bid, next grant 1 cycle after.
